mem_ctrl_nch: RTL and testbench
===============================

# mem_ctrl_nch

Parametrised successor to the two-port memory controller. It arbitrates `NCH` request channels onto the single byte-wide RAM/IO bus, with round-robin fairness, variable-length accesses of 1..`MAX_LEN` bytes, read abort on pipeline flush, and IO back-pressure handling. It sits between the bus pins of `cpu` and the instruction cache, the load/store path and any future prefetcher.

## Interface
**Parameters**
- `NCH`, default 2: number of request channels; channel 0 wins ties at reset.
- `MAX_LEN`, default 4: maximum bytes per access.
- `LEN_W`, default `$clog2(MAX_LEN)+1`: width of each length field.

**Ports**
- `clk`  in  1: single clock.
- `rst`  in  1: reset. Asynchronous and active-high.
- `rdy`  in  1: global enable; low freezes all state.
- `mem_din`  in  8: read data bus; data is valid one cycle after its address.
- `mem_dout`  out  8: write data bus.
- `mem_a`  out  32: byte address.
- `mem_wr`  out  1: 1 = write.
- `io_buffer_full`  in  1: UART buffer is full.
- `req_valid`  in  NCH: per-channel request level.
- `req_wr`  in  NCH: 1 = write.
- `req_addr`  in  NCH*32: start address.
- `req_len`  in  NCH*LEN_W: byte count, 1..MAX_LEN.
- `req_wdata`  in  NCH*8*MAX_LEN: write data, little-endian.
- `flush`  in  NCH: abort the in-flight read on that channel.
- `resp_valid`  out  NCH: one-cycle completion pulse.
- `resp_data`  out  8*MAX_LEN: read data, little-endian; bytes above `len` are zero.

## Operation
- **Request protocol.** A requester holds `req_valid` and its fields stable until it sees `resp_valid` on its channel. It drops `req_valid` on the same edge that samples `resp_valid`.
- **FSM states.** IDLE, READ, WRITE, DONE.
- **IDLE**
  - Pick the first valid channel at or after `rr_ptr`, wrapping modulo NCH.
  - Latch that channel's addr, len, wdata and wr.
  - Set `rr_ptr` to grant+1 (mod NCH).
  - Go to READ or WRITE.
  - With no valid request: stay in IDLE with `mem_wr`=0.
- **READ**
  - Issue addresses addr..addr+len-1, one per cycle, with `mem_wr`=0.
  - The byte for issue k arrives the following cycle and is stored in byte k of `resp_data`.
  - After the last byte is captured, go to DONE.
- **WRITE**
  - Issue byte k at addr+k with `mem_wr`=1, one per cycle.
  - If `mem_a[17:16]`==2'b11 and `io_buffer_full`=1: hold the current byte, drive `mem_wr`=0, and do not advance.
  - After the last byte is issued, go to DONE.
- **DONE.** Pulse `resp_valid[grant]` for one cycle, then go to IDLE.
- **Abort.**
  - `flush[grant]` during READ: go straight to IDLE, with no `resp_valid` and `mem_wr`=0.
  - Writes ignore `flush`; they are committed stores.
  - `flush` on a non-granted channel has no effect here; the requester withdraws its own request.
- **`rdy` low.** All registers hold and `mem_wr` is forced to 0. Bytes returned on `mem_din` during a stall are captured when `rdy` returns, because the address is re-presented.
- **Address arithmetic.** addr+k is a 32-bit add with wrap.
- **Zero length.** `len`=0 is treated as 1.

## Timing
- **Reset values.**
  - `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
  - `resp_valid`=0, `resp_data`=0.
  - State IDLE, `rr_ptr`=0.
- **Read latency.** With grant at edge E0, the first address appears in cycle E0+1 and `resp_valid` is high in cycle E0+len+2.
- **Write latency.** With no stalls, `resp_valid` is high in cycle E0+len+1.
- **Throughput.** One byte per cycle. There is at least one IDLE cycle between accesses.
- **Simultaneous `flush` and last-byte capture.** The flush wins: no response.
- **Reset mid-access.** Everything returns to reset values immediately. Any partial write stays in memory.

## Structure
- **Shared package / `constants.v`:**
  - `` `IO_BASE_HI `` (2'b11).
  - State encodings.
  - `` `Data_Bus ``.
- **Sub-module `rr_arbiter`:** parametrised by NCH. Inputs `req` and `ptr`; outputs one-hot `grant` and its index. Purely combinational; `rr_ptr` lives in the parent.
- **Instantiation in `cpu`:** replaces `mem_ctrl`, with ICache on channel 0 and LSB on channel 1.

## Test plan
- **Word read.** Ch0 reads len=4 at 0x100; RAM holds 0x11,0x22,0x33,0x44 → `resp_valid[0]` at E0+6 with `resp_data`=0x44332211.
- **Round-robin.** Ch0 and ch1 both request continuously → grants alternate 0,1,0,1. With only ch1 valid, ch1 is granted every access.
- **IO back-pressure.** Ch1 writes len=1 to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` stays 0 for those 3 cycles, one write of the byte follows, then `resp_valid[1]`.
- **Abort.** Ch0 reads len=4; assert `flush[0]` on the second byte → no `resp_valid`, next cycle is IDLE, and a pending ch1 request is granted.
- **Freeze.** `rdy` is low for 5 cycles in the middle of a len=2 read → the result is identical to the unstalled read and `mem_wr` stays 0 throughout.
- **Reset.** Assert `rst` during a write → all outputs are at reset values before the next edge, and `rr_ptr` returns to 0.

Source files
------------

// File: rtl/mem_ctrl_nch_pkg.sv
// Shared constants and state encoding for the multi-channel byte-bus memory controller.
package mem_ctrl_nch_pkg;

   localparam logic [1:0] IO_BASE_HI = 2'b11;
   localparam int         DATA_BUS_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NCH   = 2,
   parameter int PTR_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0]   req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NCH-1:0]   grant,
   output logic [PTR_W-1:0] grant_idx
);

   always_comb begin
      int               cand;
      logic [PTR_W-1:0] cidx;
      logic             found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cidx      = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NCH) cand = cand - NCH;
         cidx = PTR_W'(cand);
         if (!found && req[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/mem_ctrl_nch.sv
// Arbitrates NCH request channels onto one byte-wide RAM/IO bus, 1..MAX_LEN bytes per access.
module mem_ctrl_nch
   import mem_ctrl_nch_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int MAX_LEN = 4,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic [7:0]                     mem_din,
   output logic [7:0]                     mem_dout,
   output logic [31:0]                    mem_a,
   output logic                           mem_wr,
   input  logic                           io_buffer_full,
   input  logic [NCH-1:0]                 req_valid,
   input  logic [NCH-1:0]                 req_wr,
   input  logic [NCH*32-1:0]              req_addr,
   input  logic [NCH*LEN_W-1:0]           req_len,
   input  logic [NCH*DATA_BUS_W*MAX_LEN-1:0] req_wdata,
   input  logic [NCH-1:0]                 flush,
   output logic [NCH-1:0]                 resp_valid,
   output logic [DATA_BUS_W*MAX_LEN-1:0]  resp_data
);

   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW    = DATA_BUS_W * MAX_LEN;

   logic [31:0]      addr_arr  [NCH];
   logic [LEN_W-1:0] len_arr   [NCH];
   logic [DW-1:0]    wdata_arr [NCH];

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*32 +: 32];
         assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
         assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      end
   endgenerate

   state_t           state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             first_q, first_d;
   logic [DW-1:0]    data_q, data_d;

   logic [NCH-1:0]   arb_grant;
   logic [PTR_W-1:0] arb_idx;
   logic [LEN_W-1:0] len_raw, len_sel, last_idx, off;
   logic             io_block;

   rr_arbiter #(.NCH(NCH), .PTR_W(PTR_W)) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign len_raw   = len_arr[arb_idx];
   assign last_idx  = len_q - LEN_W'(1);
   assign resp_data = data_q;

   always_comb begin
      len_sel = len_raw;
      if (len_raw == '0)               len_sel = LEN_W'(1);
      else if (int'(len_raw) > MAX_LEN) len_sel = LEN_W'(MAX_LEN);
   end

   // While stalled, a read re-presents the byte awaiting capture so it returns once rdy is back.
   always_comb begin
      off = idx_q;
      if (state_q == ST_READ && rdy && !first_q && idx_q != last_idx) off = idx_q + LEN_W'(1);
      mem_a    = '0;
      mem_dout = '0;
      if (state_q == ST_READ || state_q == ST_WRITE) mem_a = addr_q + 32'(off);
      if (state_q == ST_WRITE) begin
         for (int b = 0; b < MAX_LEN; b++) begin
            if (idx_q == LEN_W'(b)) mem_dout = wdata_q[b*8 +: 8];
         end
      end
      io_block = (mem_a[17:16] == IO_BASE_HI) && io_buffer_full;
      mem_wr   = rdy && (state_q == ST_WRITE) && !io_block;
      resp_valid = '0;
      if (state_q == ST_DONE && rdy) resp_valid[grant_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      len_d    = len_q;
      wdata_d  = wdata_q;
      idx_d    = idx_q;
      first_d  = first_q;
      data_d   = data_q;
      if (rdy) begin
         case (state_q)
            ST_IDLE: begin
               if (|arb_grant) begin
                  grant_d  = arb_idx;
                  addr_d   = addr_arr[arb_idx];
                  len_d    = len_sel;
                  wdata_d  = wdata_arr[arb_idx];
                  idx_d    = '0;
                  first_d  = 1'b1;
                  data_d   = '0;
                  rr_ptr_d = (int'(arb_idx) == NCH - 1) ? '0 : arb_idx + PTR_W'(1);
                  state_d  = req_wr[arb_idx] ? ST_WRITE : ST_READ;
               end
            end
            ST_READ: begin
               // The first read cycle only issues; captures lag issues by one cycle.
               if (flush[grant_q]) begin
                  state_d = ST_IDLE;
               end else if (first_q) begin
                  first_d = 1'b0;
               end else begin
                  for (int b = 0; b < MAX_LEN; b++) begin
                     if (idx_q == LEN_W'(b)) data_d[b*8 +: 8] = mem_din;
                  end
                  if (idx_q == last_idx) state_d = ST_DONE;
                  else                   idx_d   = idx_q + LEN_W'(1);
               end
            end
            ST_WRITE: begin
               if (!io_block) begin
                  if (idx_q == last_idx) state_d = ST_DONE;
                  else                   idx_d   = idx_q + LEN_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         wdata_q  <= '0;
         idx_q    <= '0;
         first_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         wdata_q  <= wdata_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         data_q   <= data_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl_nch.sv
// Directed bench for mem_ctrl_nch with a registered-read RAM model and hand-computed expectations.
module tb_mem_ctrl_nch;
   import mem_ctrl_nch_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  req_valid, req_wr, flush, resp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [5:0]  req_len;
   logic [31:0] resp_data;

   logic [7:0]  ram [0:4095];
   int          wr_cnt = 0, resp0_cnt = 0, stall_wr = 0;
   logic [31:0] last_wr_addr = '0;
   logic [7:0]  last_wr_data = '0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   mem_ctrl_nch dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
      .req_wdata(req_wdata), .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data)
   );

   always @(posedge clk) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= mem_a;
         last_wr_data <= mem_dout;
      end
      if (resp_valid[0]) resp0_cnt <= resp0_cnt + 1;
      if (!rdy && mem_wr) stall_wr <= stall_wr + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int ch, input bit wr, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wd);
      req_wr[ch]            = wr;
      req_addr[ch*32 +: 32] = addr;
      req_len[ch*3 +: 3]    = len;
      req_wdata[ch*32 +: 32] = wd;
      req_valid[ch]         = 1'b1;
   endtask

   task automatic run(input int ch, input bit wr, input logic [31:0] addr, input logic [2:0] len,
                      input logic [31:0] wd, input int exp_lat, input bit chk_data,
                      input logic [31:0] exp_data, input string tag);
      int n;
      @(negedge clk);
      set_req(ch, wr, addr, len, wd);
      n = 0;
      while (n < 40 && !resp_valid[ch]) begin
         @(negedge clk);
         n++;
      end
      req_valid[ch] = 1'b0;
      chk({tag, " latency"}, 64'(n), 64'(exp_lat));
      if (chk_data) chk({tag, " data"}, 64'(resp_data), 64'(exp_data));
      $display("txn %s ch=%0d wr=%0d addr=%h len=%0d latency=%0d data=%h", tag, ch, wr, addr, len, n, resp_data);
   endtask

   initial begin
      int n, g, w0, r0, s0;
      rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
      req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0; flush = '0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      ram[12'h200] = 8'hA5; ram[12'h201] = 8'h5A;
      ram[12'hFFF] = 8'h77; ram[12'h000] = 8'h66;

      @(negedge clk); @(negedge clk);
      chk("reset mem_a", 64'(mem_a), 0);
      chk("reset mem_dout", 64'(mem_dout), 0);
      chk("reset mem_wr", 64'(mem_wr), 0);
      chk("reset resp_valid", 64'(resp_valid), 0);
      chk("reset resp_data", 64'(resp_data), 0);
      rst = 1'b0;

      // Both channels requesting continuously: grants must alternate starting with ch0.
      set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
      set_req(1, 1'b0, 32'h200, 3'd2, 32'h0);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         @(negedge clk);
         while (n < 40 && resp_valid == 2'b00) begin
            @(negedge clk);
            n++;
         end
         g = resp_valid[1] ? 1 : 0;
         chk("rr grant", 64'(g), 64'(i % 2));
         chk("rr data", 64'(resp_data), (i % 2 == 1) ? 64'h5AA5 : 64'h11);
         $display("txn rr step=%0d ch=%0d data=%h", i, g, resp_data);
         req_valid[g] = 1'b0;
         @(negedge clk);
         if (i < 3) req_valid[g] = 1'b1;
         else       req_valid = '0;
      end

      run(1, 1'b0, 32'h200, 3'd2, 32'h0, 4, 1'b1, 32'h5AA5, "ch1 only a");
      run(1, 1'b0, 32'h200, 3'd2, 32'h0, 4, 1'b1, 32'h5AA5, "ch1 only b");
      run(0, 1'b0, 32'h100, 3'd4, 32'h0, 6, 1'b1, 32'h44332211, "word read");
      run(0, 1'b0, 32'h100, 3'd0, 32'h0, 3, 1'b1, 32'h11, "zero len");
      run(0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0, 4, 1'b1, 32'h6677, "addr wrap");

      w0 = wr_cnt;
      run(0, 1'b1, 32'h40, 3'd3, 32'h00CC_BBAA, 4, 1'b0, 32'h0, "write len3");
      chk("write count", 64'(wr_cnt - w0), 3);
      chk("write last addr", 64'(last_wr_addr), 64'h42);
      chk("write last data", 64'(last_wr_data), 64'hCC);

      // IO back-pressure: buffer full across the first three write cycles.
      w0 = wr_cnt;
      @(negedge clk);
      io_buffer_full = 1'b1;
      set_req(1, 1'b1, 32'h0003_0000, 3'd1, 32'h0000_00C3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("io hold mem_wr", 64'(mem_wr), 0);
      end
      chk("io hold mem_a", 64'(mem_a), 64'h3_0000);
      @(posedge clk);
      #1 io_buffer_full = 1'b0;
      @(negedge clk);
      chk("io write mem_wr", 64'(mem_wr), 1);
      chk("io write mem_dout", 64'(mem_dout), 64'hC3);
      @(negedge clk);
      chk("io resp_valid", 64'(resp_valid), 64'b10);
      req_valid[1] = 1'b0;
      chk("io write count", 64'(wr_cnt - w0), 1);
      chk("io write addr", 64'(last_wr_addr), 64'h3_0000);
      $display("txn io_write ch=1 addr=00030000 writes=%0d", wr_cnt - w0);

      // Abort: flush ch0 on its second byte while ch1 is waiting.
      r0 = resp0_cnt;
      @(negedge clk);
      set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
      @(negedge clk);
      set_req(1, 1'b0, 32'h200, 3'd1, 32'h0);
      @(negedge clk);
      flush[0] = 1'b1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      flush[0] = 1'b0;
      chk("abort state idle", 64'(dut.state_q), 64'(ST_IDLE));
      chk("abort resp_valid", 64'(resp_valid), 0);
      chk("abort mem_wr", 64'(mem_wr), 0);
      n = 0;
      while (n < 40 && !resp_valid[1]) begin
         @(negedge clk);
         n++;
      end
      req_valid[1] = 1'b0;
      chk("abort ch1 latency", 64'(n), 3);
      chk("abort ch1 data", 64'(resp_data), 64'hA5);
      chk("abort no ch0 resp", 64'(resp0_cnt - r0), 0);
      $display("txn abort ch0 flushed, ch1 latency=%0d data=%h", n, resp_data);

      // Freeze: rdy low for 5 edges in the middle of a len=2 read.
      w0 = wr_cnt;
      s0 = stall_wr;
      @(negedge clk);
      set_req(0, 1'b0, 32'h200, 3'd2, 32'h0);
      @(negedge clk); @(negedge clk);
      rdy = 1'b0;
      n = 2;
      repeat (5) begin
         @(negedge clk);
         n++;
      end
      rdy = 1'b1;
      while (n < 40 && !resp_valid[0]) begin
         @(negedge clk);
         n++;
      end
      req_valid[0] = 1'b0;
      chk("freeze latency", 64'(n), 9);
      chk("freeze data", 64'(resp_data), 64'h5AA5);
      chk("freeze no writes", 64'(wr_cnt - w0), 0);
      chk("freeze stall mem_wr", 64'(stall_wr - s0), 0);
      $display("txn freeze ch=0 latency=%0d data=%h", n, resp_data);

      // Reset in the middle of a write; round-robin pointer must return to ch0.
      @(negedge clk);
      set_req(0, 1'b1, 32'h80, 3'd4, 32'h0102_0304);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst mem_wr", 64'(mem_wr), 0);
      chk("midrst mem_a", 64'(mem_a), 0);
      chk("midrst mem_dout", 64'(mem_dout), 0);
      chk("midrst resp_valid", 64'(resp_valid), 0);
      chk("midrst resp_data", 64'(resp_data), 0);
      chk("midrst state", 64'(dut.state_q), 64'(ST_IDLE));
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
      set_req(1, 1'b0, 32'h200, 3'd2, 32'h0);
      n = 0;
      while (n < 40 && resp_valid == 2'b00) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      chk("post reset grant", 64'(resp_valid), 64'b01);
      chk("post reset data", 64'(resp_data), 64'h11);
      $display("txn post_reset resp_valid=%b data=%h", resp_valid, resp_data);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
